// File: rtl/sm_acc_requant.sv
// sm_acc_requant: sign-magnitude dot-product accumulator with rounded, saturating 8-bit requantization
module sm_acc_requant #(
  parameter int ACC_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [15:0] in_data,
  input  logic       in_last,
  input  logic [3:0] shift,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat
);
  typedef enum logic [1:0] {ACC, CALC, OUT} state_t;
  localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;
  state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, p;
  logic signed [ACC_W:0] sum;
  logic [ACC_W-1:0] pm, mag, rnd, m;
  logic [6:0] m7;
  logic [7:0] out_data_q, out_data_d;
  logic [3:0] shift_q, shift_d;
  logic ovf_q, ovf_d, out_sat_q, out_sat_d;
  logic take, done, sat_hi, sat_lo, clip;
  logic unused_bit;
  assign unused_bit = in_data[14];
  // state register
  always_ff @(posedge clk)
    state_q <= !rst_n ? ACC : state_d;
  // next-state: a group ends on its accepted last beat, results leave on handshake
  always_comb
    state_d = (state_q == ACC && take && in_last) ? CALC :
              (state_q == CALC) ? OUT :
              (state_q == OUT && out_ready) ? ACC : state_q;
  // handshake and result outputs
  always_comb begin
    in_ready  = state_q == ACC;
    out_valid = state_q == OUT;
    out_data  = out_data_q;
    out_sat   = out_sat_q;
  end
  // saturating accumulate and requantize arithmetic
  always_comb begin
    take   = in_valid && state_q == ACC;
    done   = state_q == OUT && out_ready;
    pm     = {{(ACC_W-14){1'b0}}, in_data[13:0]};
    p      = in_data[15] ? -pm : pm;
    sum    = {acc_q[ACC_W-1], acc_q} + {p[ACC_W-1], p};
    sat_hi = sum > SUM_MAX;
    sat_lo = sum < SUM_MIN;
    mag    = acc_q[ACC_W-1] ? -acc_q : acc_q;
    rnd    = shift_q == 4'd0 ? '0 : ACC_W'(1) << (shift_q - 4'd1);
    m      = (mag + rnd) >> shift_q;
    clip   = m > ACC_W'(127);
    m7     = clip ? 7'h7f : m[6:0];
    acc_d  = done ? '0 :
             !take ? acc_q :
             sat_hi ? SUM_MAX[ACC_W-1:0] :
             sat_lo ? SUM_MIN[ACC_W-1:0] : sum[ACC_W-1:0];
    ovf_d      = done ? 1'b0 : take ? (ovf_q | sat_hi | sat_lo) : ovf_q;
    shift_d    = (take && in_last) ? shift : shift_q;
    out_data_d = state_q == CALC ? {acc_q[ACC_W-1] && m7 != 7'd0, m7} : out_data_q;
    out_sat_d  = state_q == CALC ? (clip | ovf_q) : out_sat_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      shift_q    <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end
endmodule

// File: tb/tb_sm_acc_requant.sv
// tb_sm_acc_requant: directed bench checking 24- and 16-bit accumulators against a group-level model
module tb_sm_acc_requant;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [15:0] in_data = 0;
  logic [3:0] shift = 0;
  logic rdy[2], ov[2], sat[2];
  logic [7:0] od[2];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  sm_acc_requant #(.ACC_W(24)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_last(in_last), .shift(shift), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_sat(sat[0]));
  sm_acc_requant #(.ACC_W(16)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_last(in_last), .shift(shift), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_sat(sat[1]));
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic longint lim(int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic logic [8:0] requant(longint a, bit f, int sh);
    longint mag, m;
    bit clip;
    mag  = a < 0 ? -a : a;
    m    = (mag + (sh > 0 ? (longint'(1) << (sh - 1)) : 0)) >> sh;
    clip = m > 127;
    return {clip | f, a < 0 && m != 0, clip ? 7'd127 : m[6:0]};
  endfunction
  longint macc[2], pv, s;
  bit movf[2], es[2], exp_rdy, exp_ov, armed;
  logic [7:0] ed[2];
  logic [8:0] r;
  int wv[2] = '{24, 16};
  int wcnt;
  // group-level model: results appear two cycles after the last beat, input closed until handshake
  initial forever begin
    @(negedge clk);
    if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) exp_ov = 1;
    end
    if (armed)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("in_ready%0d", i), rdy[i], exp_rdy);
        chk($sformatf("out_valid%0d", i), ov[i], exp_ov);
        if (exp_ov) begin
          chk($sformatf("out_data%0d", i), od[i], ed[i]);
          chk($sformatf("out_sat%0d", i), sat[i], es[i]);
        end
      end
    if (!rst_n) begin
      armed = 1; exp_rdy = 1; exp_ov = 0; wcnt = 0;
      for (int i = 0; i < 2; i++) begin macc[i] = 0; movf[i] = 0; end
    end else if (armed) begin
      if (exp_ov && out_ready) begin
        exp_ov = 0; exp_rdy = 1;
        for (int i = 0; i < 2; i++) begin macc[i] = 0; movf[i] = 0; end
      end else if (exp_rdy && in_valid) begin
        pv = in_data[15] ? -longint'(in_data[13:0]) : longint'(in_data[13:0]);
        for (int i = 0; i < 2; i++) begin
          s = macc[i] + pv;
          if (s > lim(wv[i])) begin s = lim(wv[i]); movf[i] = 1; end
          else if (s < -lim(wv[i])) begin s = -lim(wv[i]); movf[i] = 1; end
          macc[i] = s;
          if (in_last) begin
            r = requant(macc[i], movf[i], int'(shift));
            ed[i] = r[7:0];
            es[i] = r[8];
          end
        end
        if (in_last) begin exp_rdy = 0; wcnt = 2; end
      end
    end
  end
  task automatic beat(logic [15:0] d, bit l, logic [3:0] sh);
    bit ok = 0;
    in_valid = 1; in_data = d; in_last = l; shift = sh;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = rdy[0];
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask
  task automatic result(logic [7:0] d, bit st);
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = ov[0];
      if (!ok) begin @(posedge clk); #1; end
    end
    if (!ok) chk("out_timeout", 0, 1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lit_data%0d", i), od[i], d);
      chk($sformatf("lit_sat%0d", i), sat[i], st);
    end
    @(posedge clk); #1;
  endtask
  task automatic pulse_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", rdy[i], 1);
      chk("rst_out_valid", ov[i], 0);
      chk("rst_out_data", od[i], 0);
      chk("rst_out_sat", sat[i], 0);
    end
    @(posedge clk); #1;
    beat(16'h0040, 1, 0); result(8'h40, 0);
    beat(16'h0064, 0, 1); beat(16'h801E, 1, 1); result(8'h23, 0);
    beat(16'h0003, 1, 1); result(8'h02, 0);
    beat(16'h8003, 1, 1); result(8'h82, 0);
    beat(16'h3FFF, 1, 0); result(8'h7F, 1);
    beat(16'hBFFF, 1, 0); result(8'hFF, 1);
    beat(16'h0005, 0, 0); beat(16'h8005, 1, 0); result(8'h00, 0);
    beat(16'h8000, 1, 0); result(8'h00, 0);
    beat(16'h4040, 1, 0); result(8'h40, 0);
    beat(16'h8001, 1, 1); result(8'h81, 0);
    beat(16'h0100, 1, 15); result(8'h00, 0);
    out_ready = 0;
    beat(16'h0020, 1, 0); result(8'h20, 0);
    repeat (5) begin
      in_valid = 1; in_data = 16'h0011; in_last = 1;
      @(posedge clk); #1;
    end
    chk("hold_data", od[0], 8'h20);
    in_valid = 0; in_last = 0; out_ready = 1;
    @(posedge clk); #1;
    beat(16'h0009, 1, 0); result(8'h09, 0);
    beat(16'h0010, 0, 0); beat(16'h0010, 0, 0);
    pulse_reset();
    beat(16'h0005, 1, 0); result(8'h05, 0);
    beat(16'h0040, 1, 0);
    pulse_reset();
    repeat (4) @(posedge clk); #1;
    beat(16'h0007, 1, 0); result(8'h07, 0);
    out_ready = 0;
    beat(16'h0030, 1, 0);
    @(posedge clk); #1;
    pulse_reset();
    out_ready = 1;
    repeat (4) @(posedge clk); #1;
    repeat (3) beat(16'h3FFF, 0, 8);
    beat(16'h3FFF, 1, 8); result(8'h7F, 1);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
